regfile_write_arbiter: RTL and testbench

Two-client round-robin arbiter sharing the single latency-insensitive write channel (EN / INDEX / DATA triple) of the multi-ported register file. Each client presents a complete write token; the arbiter grants one per cycle, latches it into a one-entry output buffer, and drives the register file's three write channels from that buffer until they are consumed. It sits between the pipeline stages that retire writes and the register file instance. It sustains one token per cycle when the register file consumes every cycle.

---
 rtl/regfile_write_arbiter_pkg.sv | 19 +
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 24 ++
 rtl/regfile_write_arbiter.sv | 87 ++++++++
 tb/tb_regfile_write_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The token struct uses the arbiter's default widths (32-bit data, 5-bit index).
package regfile_write_arbiter_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INDEX_WIDTH = 5;

    typedef struct packed {
        logic                   en;
        logic [INDEX_WIDTH-1:0] index;
        logic [DATA_WIDTH-1:0]  data;
    } token_t;

    localparam logic CLIENT0    = 1'b0;
    localparam logic CLIENT1    = 1'b1;
    // Client 1 is recorded as the last winner, so client 0 wins the first contended cycle.
    localparam logic LAST_RESET = CLIENT1;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant. The grant is one-hot, or zero when
// nothing may be loaded this cycle or no client is requesting.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       load,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (load) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last == CLIENT0) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-client round-robin arbiter feeding the register file's EN/INDEX/DATA write
// channels through a one-entry buffer that refills in the same cycle it drains.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int width = DATA_WIDTH,
    parameter int n     = INDEX_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             C0_EN_WRITE,
    input  logic [n-1:0]     C0_INDEX_WRITE,
    input  logic [width-1:0] C0_DATA_WRITE,
    input  logic             C0_WRITE_VALID,
    output logic             C0_WRITE_CONSUMED,
    input  logic             C1_EN_WRITE,
    input  logic [n-1:0]     C1_INDEX_WRITE,
    input  logic [width-1:0] C1_DATA_WRITE,
    input  logic             C1_WRITE_VALID,
    output logic             C1_WRITE_CONSUMED,
    output logic             WRITE_EN_WRITE,
    output logic             WRITE_EN_WRITE_VALID,
    input  logic             WRITE_EN_WRITE_CONSUMED,
    output logic [n-1:0]     WRITE_INDEX_WRITE,
    output logic             WRITE_INDEX_WRITE_VALID,
    input  logic             WRITE_INDEX_WRITE_CONSUMED,
    output logic [width-1:0] WRITE_DATA_WRITE,
    output logic             WRITE_DATA_WRITE_VALID,
    input  logic             WRITE_DATA_WRITE_CONSUMED
);

    typedef struct packed {
        logic             en;
        logic [n-1:0]     index;
        logic [width-1:0] data;
    } slot_t;

    logic       buf_valid;
    slot_t      buf_tok;
    logic       last;
    logic       drain;
    logic       load;
    logic [1:0] grant;
    slot_t      c0_tok;
    slot_t      c1_tok;

    assign c0_tok = '{en: C0_EN_WRITE, index: C0_INDEX_WRITE, data: C0_DATA_WRITE};
    assign c1_tok = '{en: C1_EN_WRITE, index: C1_INDEX_WRITE, data: C1_DATA_WRITE};

    // Only a full consume of all three channels frees the buffer.
    assign drain = buf_valid && WRITE_EN_WRITE_CONSUMED && WRITE_INDEX_WRITE_CONSUMED
                   && WRITE_DATA_WRITE_CONSUMED;
    assign load  = !buf_valid || drain;

    rr_arbiter2 u_rr_arbiter2 (
        .req   ({C1_WRITE_VALID, C0_WRITE_VALID}),
        .last  (last),
        .load  (load),
        .grant (grant)
    );

    assign C0_WRITE_CONSUMED = grant[0];
    assign C1_WRITE_CONSUMED = grant[1];

    // A grant overwrites the buffer even while it drains, giving one token per cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            buf_valid <= 1'b0;
            buf_tok   <= '0;
            last      <= LAST_RESET;
        end else if (grant != 2'b00) begin
            buf_valid <= 1'b1;
            buf_tok   <= grant[1] ? c1_tok : c0_tok;
            last      <= grant[1] ? CLIENT1 : CLIENT0;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

    assign WRITE_EN_WRITE          = buf_tok.en;
    assign WRITE_INDEX_WRITE       = buf_tok.index;
    assign WRITE_DATA_WRITE        = buf_tok.data;
    assign WRITE_EN_WRITE_VALID    = buf_valid;
    assign WRITE_INDEX_WRITE_VALID = buf_valid;
    assign WRITE_DATA_WRITE_VALID  = buf_valid;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed vector table, reset corner cases,
// then randomized traffic checked against a grant-order reference model.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        C0_EN_WRITE, C1_EN_WRITE;
    logic [4:0]  C0_INDEX_WRITE, C1_INDEX_WRITE;
    logic [31:0] C0_DATA_WRITE, C1_DATA_WRITE;
    logic        C0_WRITE_VALID, C1_WRITE_VALID;
    logic        C0_WRITE_CONSUMED, C1_WRITE_CONSUMED;
    logic        WRITE_EN_WRITE, WRITE_EN_WRITE_VALID, WRITE_EN_WRITE_CONSUMED;
    logic [4:0]  WRITE_INDEX_WRITE;
    logic        WRITE_INDEX_WRITE_VALID, WRITE_INDEX_WRITE_CONSUMED;
    logic [31:0] WRITE_DATA_WRITE;
    logic        WRITE_DATA_WRITE_VALID, WRITE_DATA_WRITE_CONSUMED;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.width(32), .n(5)) dut (
        .CLK                        (CLK),
        .RST_N                      (RST_N),
        .C0_EN_WRITE                (C0_EN_WRITE),
        .C0_INDEX_WRITE             (C0_INDEX_WRITE),
        .C0_DATA_WRITE              (C0_DATA_WRITE),
        .C0_WRITE_VALID             (C0_WRITE_VALID),
        .C0_WRITE_CONSUMED          (C0_WRITE_CONSUMED),
        .C1_EN_WRITE                (C1_EN_WRITE),
        .C1_INDEX_WRITE             (C1_INDEX_WRITE),
        .C1_DATA_WRITE              (C1_DATA_WRITE),
        .C1_WRITE_VALID             (C1_WRITE_VALID),
        .C1_WRITE_CONSUMED          (C1_WRITE_CONSUMED),
        .WRITE_EN_WRITE             (WRITE_EN_WRITE),
        .WRITE_EN_WRITE_VALID       (WRITE_EN_WRITE_VALID),
        .WRITE_EN_WRITE_CONSUMED    (WRITE_EN_WRITE_CONSUMED),
        .WRITE_INDEX_WRITE          (WRITE_INDEX_WRITE),
        .WRITE_INDEX_WRITE_VALID    (WRITE_INDEX_WRITE_VALID),
        .WRITE_INDEX_WRITE_CONSUMED (WRITE_INDEX_WRITE_CONSUMED),
        .WRITE_DATA_WRITE           (WRITE_DATA_WRITE),
        .WRITE_DATA_WRITE_VALID     (WRITE_DATA_WRITE_VALID),
        .WRITE_DATA_WRITE_CONSUMED  (WRITE_DATA_WRITE_CONSUMED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       c0v;
        token_t     c0;
        logic       c1v;
        token_t     c1;
        logic [2:0] cons;
        logic       exp_valid;
        token_t     exp_out;
        logic       exp_c0c;
        logic       exp_c1c;
    } vec_t;

    vec_t vecs[$];

    function automatic token_t tk(input logic en, input logic [4:0] idx, input logic [31:0] data);
        token_t t;
        t.en    = en;
        t.index = idx;
        t.data  = data;
        return t;
    endfunction

    function automatic vec_t mk(input logic c0v, input token_t c0, input logic c1v, input token_t c1,
                                input logic [2:0] cons, input logic ev, input token_t eo,
                                input logic e0, input logic e1);
        vec_t v;
        v.c0v = c0v; v.c0 = c0; v.c1v = c1v; v.c1 = c1; v.cons = cons;
        v.exp_valid = ev; v.exp_out = eo; v.exp_c0c = e0; v.exp_c1c = e1;
        return v;
    endfunction

    // cons bits: [2]=EN consumed, [1]=INDEX consumed, [0]=DATA consumed
    task automatic applyStimulus(input logic c0v, input token_t c0, input logic c1v, input token_t c1,
                                 input logic [2:0] cons);
        C0_WRITE_VALID = c0v;
        C0_EN_WRITE    = c0.en;
        C0_INDEX_WRITE = c0.index;
        C0_DATA_WRITE  = c0.data;
        C1_WRITE_VALID = c1v;
        C1_EN_WRITE    = c1.en;
        C1_INDEX_WRITE = c1.index;
        C1_DATA_WRITE  = c1.data;
        WRITE_EN_WRITE_CONSUMED    = cons[2];
        WRITE_INDEX_WRITE_CONSUMED = cons[1];
        WRITE_DATA_WRITE_CONSUMED  = cons[0];
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkValids(input string name, input logic exp);
        checkOutput({name, " en_valid"},    64'(WRITE_EN_WRITE_VALID),    64'(exp));
        checkOutput({name, " index_valid"}, 64'(WRITE_INDEX_WRITE_VALID), 64'(exp));
        checkOutput({name, " data_valid"},  64'(WRITE_DATA_WRITE_VALID),  64'(exp));
    endtask

    task automatic checkToken(input string name, input token_t exp);
        checkOutput({name, " en"},    64'(WRITE_EN_WRITE),    64'(exp.en));
        checkOutput({name, " index"}, 64'(WRITE_INDEX_WRITE), 64'(exp.index));
        checkOutput({name, " data"},  64'(WRITE_DATA_WRITE),  64'(exp.data));
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 3'b000);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Reference model state: the token the register file should currently see, and the last winner.
    logic   m_valid;
    token_t m_tok;
    int     m_last;
    token_t pend[$];

    initial begin
        token_t a0, a1, a2, b0, b1, b2, z, p, q, r, nul, s, t;
        token_t c0t, c1t;
        logic   c0v, c1v;
        logic [2:0] cons;
        logic   drain, load, g0, g1;
        int     wait0, wait1;

        z   = tk(1'b0, 5'd0,  32'h0);
        a0  = tk(1'b1, 5'd1,  32'hA000_0000);
        a1  = tk(1'b1, 5'd2,  32'hA000_0001);
        a2  = tk(1'b1, 5'd3,  32'hA000_0002);
        b0  = tk(1'b1, 5'd17, 32'hB000_0000);
        b1  = tk(1'b1, 5'd18, 32'hB000_0001);
        b2  = tk(1'b1, 5'd19, 32'hB000_0002);
        p   = tk(1'b1, 5'd3,  32'h0000_00A5);
        q   = tk(1'b1, 5'd4,  32'h0000_0011);
        r   = tk(1'b1, 5'd5,  32'h0000_0022);
        nul = tk(1'b0, 5'd7,  32'h0);
        s   = tk(1'b1, 5'd6,  32'h0000_0033);
        t   = tk(1'b1, 5'd8,  32'h0000_0044);

        // Contended alternation; each client re-presents until its token is consumed.
        vecs.push_back(mk(1, a0, 1, b0, 3'b111, 0, z,   1, 0));
        vecs.push_back(mk(1, a1, 1, b0, 3'b111, 1, a0,  0, 1));
        vecs.push_back(mk(1, a1, 1, b1, 3'b111, 1, b0,  1, 0));
        vecs.push_back(mk(1, a2, 1, b1, 3'b111, 1, a1,  0, 1));
        vecs.push_back(mk(1, a2, 1, b2, 3'b111, 1, b1,  1, 0));
        vecs.push_back(mk(0, z,  1, b2, 3'b111, 1, a2,  0, 1));
        vecs.push_back(mk(0, z,  0, z,  3'b111, 1, b2,  0, 0));
        vecs.push_back(mk(0, z,  0, z,  3'b111, 0, z,   0, 0));
        // Single client, then a 3-cycle stall, then drain grants the waiting client.
        vecs.push_back(mk(1, p,  0, z,  3'b111, 0, z,   1, 0));
        vecs.push_back(mk(1, q,  1, r,  3'b000, 1, p,   0, 0));
        vecs.push_back(mk(1, q,  1, r,  3'b000, 1, p,   0, 0));
        vecs.push_back(mk(1, q,  1, r,  3'b000, 1, p,   0, 0));
        vecs.push_back(mk(1, q,  1, r,  3'b111, 1, p,   0, 1));
        // Partial consume holds; then null-token forwarding moves the pointer to client 1.
        vecs.push_back(mk(1, q,  1, nul, 3'b110, 1, r,  0, 0));
        vecs.push_back(mk(1, q,  1, nul, 3'b111, 1, r,  1, 0));
        vecs.push_back(mk(0, z,  1, nul, 3'b111, 1, q,  0, 1));
        vecs.push_back(mk(1, s,  1, t,   3'b111, 1, nul, 1, 0));
        vecs.push_back(mk(0, z,  0, z,   3'b111, 1, s,  0, 0));

        doReset();
        @(negedge CLK);
        checkValids("reset", 1'b0);
        checkToken("reset", z);
        checkOutput("reset c0_consumed", 64'(C0_WRITE_CONSUMED), 64'(0));
        checkOutput("reset c1_consumed", 64'(C1_WRITE_CONSUMED), 64'(0));
        @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].c0v, vecs[i].c0, vecs[i].c1v, vecs[i].c1, vecs[i].cons);
            @(negedge CLK);
            checkValids($sformatf("vec%0d", i), vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                checkToken($sformatf("vec%0d", i), vecs[i].exp_out);
            checkOutput($sformatf("vec%0d c0_consumed", i), 64'(C0_WRITE_CONSUMED), 64'(vecs[i].exp_c0c));
            checkOutput($sformatf("vec%0d c1_consumed", i), 64'(C1_WRITE_CONSUMED), 64'(vecs[i].exp_c1c));
            @(posedge CLK);
            #1;
        end

        // Mid-cycle asynchronous reset with a full buffer last filled by client 1.
        applyStimulus(1'b0, z, 1'b1, tk(1'b1, 5'd9, 32'h55), 3'b000);
        @(negedge CLK);
        checkOutput("arst fill c1_consumed", 64'(C1_WRITE_CONSUMED), 64'(1));
        @(posedge CLK);
        #1;
        applyStimulus(1'b0, z, 1'b0, z, 3'b000);
        @(negedge CLK);
        checkValids("arst before", 1'b1);
        checkToken("arst before", tk(1'b1, 5'd9, 32'h55));
        #2;
        RST_N = 1'b0;
        #1;
        checkValids("arst during", 1'b0);
        checkToken("arst during", z);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus(1'b1, a0, 1'b1, b0, 3'b111);
        @(negedge CLK);
        checkOutput("arst after c0_consumed", 64'(C0_WRITE_CONSUMED), 64'(1));
        checkOutput("arst after c1_consumed", 64'(C1_WRITE_CONSUMED), 64'(0));
        @(posedge CLK);
        #1;
        applyStimulus(1'b0, z, 1'b0, z, 3'b111);
        @(negedge CLK);
        checkValids("arst after out", 1'b1);
        checkToken("arst after out", a0);

        // Randomized traffic against the reference model.
        doReset();
        m_valid = 1'b0;
        m_tok   = '0;
        m_last  = 1;
        pend.delete();
        c0v = 1'b0; c1v = 1'b0;
        c0t = '0;   c1t = '0;
        wait0 = 0;  wait1 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cons = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            applyStimulus(c0v, c0t, c1v, c1t, cons);
            @(negedge CLK);
            drain = m_valid && (cons == 3'b111);
            load  = !m_valid || drain;
            g0 = 1'b0;
            g1 = 1'b0;
            if (load) begin
                if (c0v && c1v) begin
                    g1 = (m_last == 0);
                    g0 = !g1;
                end else begin
                    g0 = c0v;
                    g1 = c1v;
                end
            end
            checkOutput("rand valid", 64'(WRITE_EN_WRITE_VALID), 64'(pend.size() != 0));
            if (pend.size() != 0)
                checkToken("rand token", pend[0]);
            checkOutput("rand c0_consumed", 64'(C0_WRITE_CONSUMED), 64'(g0));
            checkOutput("rand c1_consumed", 64'(C1_WRITE_CONSUMED), 64'(g1));
            if (drain)
                void'(pend.pop_front());
            if (g0 || g1) begin
                if (pend.size() != 0)
                    void'(pend.pop_front());
                pend.push_back(g1 ? c1t : c0t);
                m_last = g1 ? 1 : 0;
            end
            m_valid = (pend.size() != 0);
            // A client left waiting through two grants to the other would violate fairness.
            wait0 = (c0v && g1) ? wait0 + 1 : 0;
            wait1 = (c1v && g0) ? wait1 + 1 : 0;
            if (wait0 > 1 || wait1 > 1)
                checkOutput("rand fairness wait", 64'(wait0 > wait1 ? wait0 : wait1), 64'(1));
            if (g0 || !c0v) begin
                c0v = ($urandom_range(0, 2) != 0);
                c0t = tk(1'($urandom), 5'($urandom), $urandom);
            end
            if (g1 || !c1v) begin
                c1v = ($urandom_range(0, 2) != 0);
                c1t = tk(1'($urandom), 5'($urandom), $urandom);
            end
            @(posedge CLK);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
